// File: rtl/result_collect.sv
// result_collect: gathers results from NUNIT functional units that cannot be
// back-pressured. Each unit has its own DEPTH-entry queue. A round-robin
// arbiter drains the queues into a single registered writeback port.
// Per-hart flush invalidates queued and output entries of that hart. Flushed
// queue entries are marked dead and dropped silently at the queue head.
// Optional feature macro: WB_BYPASS_EN. When it is defined, an arrival that
// finds every queue empty while the output register is free is loaded
// straight into the output register, which shortens latency by one cycle.
module result_collect #(
    parameter int RV       = 64,
    parameter int LNCOMMIT = 5,
    parameter int NHART    = 1,
    parameter int NUNIT    = 4,
    parameter int DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUNIT*RV-1:0]       unit_result,
    input  logic [NUNIT*LNCOMMIT-1:0] unit_rd,
    input  logic [NUNIT*NHART-1:0]    unit_makes_rd,
    output logic [NUNIT-1:0]          unit_stall,
    input  logic [NHART-1:0]          flush,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [LNCOMMIT-1:0]       wb_rd,
    output logic [RV-1:0]             wb_result,
    output logic [NHART-1:0]          wb_hart,
    output logic                      overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int UW = (NUNIT > 1) ? $clog2(NUNIT) : 1;
    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_C = CW'(DEPTH - 2);
    localparam logic [UW-1:0] LAST_C  = UW'(NUNIT - 1);

    // Queue storage and bookkeeping
    logic [LNCOMMIT-1:0] q_rd_r   [NUNIT][DEPTH];
    logic [RV-1:0]       q_res_r  [NUNIT][DEPTH];
    logic [NHART-1:0]    q_hart_r [NUNIT][DEPTH];
    logic                q_dead_r [NUNIT][DEPTH];
    logic [AW-1:0]       wr_ptr_r [NUNIT];
    logic [AW-1:0]       rd_ptr_r [NUNIT];
    logic [CW-1:0]       cnt_r    [NUNIT];
    logic [UW-1:0]       rr_ptr_r;
    logic [NUNIT-1:0]    stall_r;
    logic                overflow_r;
    logic                wb_valid_r;
    logic [LNCOMMIT-1:0] wb_rd_r;
    logic [RV-1:0]       wb_result_r;
    logic [NHART-1:0]    wb_hart_r;

    // Combinational decode
    logic [LNCOMMIT-1:0] in_rd_s    [NUNIT];
    logic [RV-1:0]       in_res_s   [NUNIT];
    logic [NHART-1:0]    in_hart_s  [NUNIT];
    logic [CW-1:0]       cnt_next_s [NUNIT];
    logic [NUNIT-1:0]    arrive_s;
    logic [NUNIT-1:0]    head_dead_s;
    logic [NUNIT-1:0]    head_live_s;
    logic [NUNIT-1:0]    arb_req_s;
    logic [NUNIT-1:0]    pop_s;
    logic [NUNIT-1:0]    push_s;
    logic [NUNIT-1:0]    push_ok_s;
    logic [NUNIT-1:0]    drop_s;
    logic                all_empty_s;
    logic                out_kill_s;
    logic                load_en_s;
    logic                use_bypass_s;
    logic                grant_found_s;
    logic [UW-1:0]       grant_idx_s;
    logic [LNCOMMIT-1:0] sel_rd_s;
    logic [RV-1:0]       sel_res_s;
    logic [NHART-1:0]    sel_hart_s;

    // Unpack unit buses, classify queue heads and decide whether the output register loads
    always_comb begin
        all_empty_s = 1'b1;
        for (int u = 0; u < NUNIT; u++) begin
            in_rd_s[u]   = unit_rd[u*LNCOMMIT +: LNCOMMIT];
            in_res_s[u]  = unit_result[u*RV +: RV];
            in_hart_s[u] = unit_makes_rd[u*NHART +: NHART];
            // An arrival for a hart being flushed this edge is discarded.
            arrive_s[u]  = (|in_hart_s[u]) && ((in_hart_s[u] & flush) == '0);
            if (cnt_r[u] != '0) begin
                head_dead_s[u] = q_dead_r[u][rd_ptr_r[u]] ||
                                 ((q_hart_r[u][rd_ptr_r[u]] & flush) != '0);
                all_empty_s    = 1'b0;
            end else begin
                head_dead_s[u] = 1'b0;
            end
            head_live_s[u] = (cnt_r[u] != '0) && !head_dead_s[u];
        end
        out_kill_s = wb_valid_r && ((wb_hart_r & flush) != '0);
        load_en_s  = !wb_valid_r || wb_ready || out_kill_s;
    end

    // Choose the request set and pick the round-robin winner starting at rr_ptr
    always_comb begin
        int slot;
        slot          = 0;
        arb_req_s     = '0;
        use_bypass_s  = 1'b0;
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
`ifdef WB_BYPASS_EN
        if (load_en_s && all_empty_s) begin
            arb_req_s    = arrive_s;
            use_bypass_s = 1'b1;
        end else if (load_en_s) begin
            arb_req_s = head_live_s;
        end else begin
            arb_req_s = '0;
        end
`else
        if (load_en_s) begin
            arb_req_s = head_live_s;
        end else begin
            arb_req_s = '0;
        end
`endif
        for (int k = 0; k < NUNIT; k++) begin
            slot = (int'(rr_ptr_r) + k) % NUNIT;
            if (!grant_found_s && arb_req_s[slot]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = UW'(slot);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Per-queue push/pop decisions, overflow detection and next occupancy
    always_comb begin
        for (int u = 0; u < NUNIT; u++) begin
            // Dead heads leave the queue on their own without using the writeback port.
            pop_s[u]     = head_dead_s[u] ||
                           (grant_found_s && !use_bypass_s && (grant_idx_s == UW'(u)));
            push_s[u]    = arrive_s[u] &&
                           !(grant_found_s && use_bypass_s && (grant_idx_s == UW'(u)));
            push_ok_s[u] = push_s[u] && ((cnt_r[u] != FULL_C) || pop_s[u]);
            drop_s[u]    = push_s[u] && !push_ok_s[u];
            case ({push_ok_s[u], pop_s[u]})
                2'b10:   cnt_next_s[u] = cnt_r[u] + CW'(1);
                2'b01:   cnt_next_s[u] = cnt_r[u] - CW'(1);
                default: cnt_next_s[u] = cnt_r[u];
            endcase
        end
    end

    // Writeback source: the unit input on a bypass, otherwise the granted queue head
    always_comb begin
        sel_rd_s   = '0;
        sel_res_s  = '0;
        sel_hart_s = '0;
        if (use_bypass_s) begin
            sel_rd_s   = in_rd_s[grant_idx_s];
            sel_res_s  = in_res_s[grant_idx_s];
            sel_hart_s = in_hart_s[grant_idx_s];
        end else begin
            sel_rd_s   = q_rd_r[grant_idx_s][rd_ptr_r[grant_idx_s]];
            sel_res_s  = q_res_r[grant_idx_s][rd_ptr_r[grant_idx_s]];
            sel_hart_s = q_hart_r[grant_idx_s][rd_ptr_r[grant_idx_s]];
        end
    end

    // Queue pointers, counts, entry storage and dead marking on flush
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int u = 0; u < NUNIT; u++) begin
                wr_ptr_r[u] <= '0;
                rd_ptr_r[u] <= '0;
                cnt_r[u]    <= '0;
            end
        end else begin
            for (int u = 0; u < NUNIT; u++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if ((q_hart_r[u][i] & flush) != '0) begin
                        q_dead_r[u][i] <= 1'b1;
                    end
                end
                if (push_ok_s[u]) begin
                    q_rd_r[u][wr_ptr_r[u]]   <= in_rd_s[u];
                    q_res_r[u][wr_ptr_r[u]]  <= in_res_s[u];
                    q_hart_r[u][wr_ptr_r[u]] <= in_hart_s[u];
                    q_dead_r[u][wr_ptr_r[u]] <= 1'b0;
                    wr_ptr_r[u]              <= wr_ptr_r[u] + AW'(1);
                end
                if (pop_s[u]) begin
                    rd_ptr_r[u] <= rd_ptr_r[u] + AW'(1);
                end
                cnt_r[u] <= cnt_next_s[u];
            end
        end
    end

    // Stall requests track the post-edge occupancy; overflow is sticky until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            for (int u = 0; u < NUNIT; u++) begin
                stall_r[u] <= (cnt_next_s[u] >= STALL_C);
            end
            overflow_r <= overflow_r | (|drop_s);
        end
    end

    // Output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_r  <= 1'b0;
            wb_rd_r     <= '0;
            wb_result_r <= '0;
            wb_hart_r   <= '0;
            rr_ptr_r    <= '0;
        end else if (load_en_s) begin
            if (grant_found_s) begin
                wb_valid_r  <= 1'b1;
                wb_rd_r     <= sel_rd_s;
                wb_result_r <= sel_res_s;
                wb_hart_r   <= sel_hart_s;
                rr_ptr_r    <= (grant_idx_s == LAST_C) ? '0 : grant_idx_s + UW'(1);
            end else begin
                wb_valid_r <= 1'b0;
            end
        end
    end

    assign unit_stall = stall_r;
    assign overflow   = overflow_r;
    assign wb_valid   = wb_valid_r;
    assign wb_rd      = wb_rd_r;
    assign wb_result  = wb_result_r;
    assign wb_hart    = wb_hart_r;

endmodule

// File: tb/tb_result_collect.sv
// Self-checking bench for result_collect (NHART=2 build).
// Each driven result that should be written back is pushed to a scoreboard.
// The monitor matches every accepted writeback against the oldest pending
// entry of the same unit. The unit number is carried in result bits [63:60].
module tb_result_collect;

    localparam int RV       = 64;
    localparam int LNCOMMIT = 5;
    localparam int NHART    = 2;
    localparam int NUNIT    = 4;
    localparam int DEPTH    = 4;

    logic                      clk;
    logic                      reset;
    logic [NUNIT*RV-1:0]       unit_result;
    logic [NUNIT*LNCOMMIT-1:0] unit_rd;
    logic [NUNIT*NHART-1:0]    unit_makes_rd;
    logic [NUNIT-1:0]          unit_stall;
    logic [NHART-1:0]          flush;
    logic                      wb_valid;
    logic                      wb_ready;
    logic [LNCOMMIT-1:0]       wb_rd;
    logic [RV-1:0]             wb_result;
    logic [NHART-1:0]          wb_hart;
    logic                      overflow;

    typedef struct {
        int                  unit;
        logic [LNCOMMIT-1:0] rd;
        logic [RV-1:0]       res;
        logic [NHART-1:0]    hart;
    } exp_t;

    exp_t                sb_q[$];
    logic [LNCOMMIT-1:0] got_rd_q[$];
    time                 got_t_q[$];
    int                  checks   = 0;
    int                  failures = 0;
    int                  mon_idx;

    result_collect #(
        .RV(RV), .LNCOMMIT(LNCOMMIT), .NHART(NHART), .NUNIT(NUNIT), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .unit_result(unit_result), .unit_rd(unit_rd), .unit_makes_rd(unit_makes_rd),
        .unit_stall(unit_stall), .flush(flush),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd(wb_rd), .wb_result(wb_result), .wb_hart(wb_hart),
        .overflow(overflow)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [RV-1:0] mkres(input int u, input logic [59:0] v);
        return {4'(u), v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        unit_makes_rd = '0;
        unit_rd       = '0;
        unit_result   = '0;
        flush         = '0;
    endtask

    task automatic put(input int u, input logic [LNCOMMIT-1:0] rd, input logic [RV-1:0] res,
                       input logic [NHART-1:0] hart, input bit expect_it);
        exp_t e;
        unit_rd[u*LNCOMMIT +: LNCOMMIT] = rd;
        unit_result[u*RV +: RV]         = res;
        unit_makes_rd[u*NHART +: NHART] = hart;
        if (expect_it) begin
            e.unit = u;
            e.rd   = rd;
            e.res  = res;
            e.hart = hart;
            sb_q.push_back(e);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || wb_valid) && n < 60) begin
            tick();
            n++;
        end
        for (int i = 0; i < 4; i++) tick();
        check_val(tag, 64'(sb_q.size()), 64'd0);
    endtask

    // Scoreboard monitor: every accepted, unflushed writeback must match its unit's oldest expectation
    always @(negedge clk) begin
        if (!reset && wb_valid && wb_ready && ((wb_hart & flush) == '0)) begin
            got_rd_q.push_back(wb_rd);
            got_t_q.push_back($time);
            mon_idx = -1;
            for (int i = 0; i < sb_q.size(); i++) begin
                if (mon_idx < 0 && sb_q[i].unit == int'(wb_result[63:60])) mon_idx = i;
            end
            check_val("wb_expected", (mon_idx >= 0) ? 64'd1 : 64'd0, 64'd1);
            if (mon_idx >= 0) begin
                check_val("wb_rd", 64'(wb_rd), 64'(sb_q[mon_idx].rd));
                check_val("wb_result", wb_result, sb_q[mon_idx].res);
                check_val("wb_hart", 64'(wb_hart), 64'(sb_q[mon_idx].hart));
                sb_q.delete(mon_idx);
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Main stimulus
    initial begin
        logic [63:0] rnd;
        idle();
        reset    = 1'b1;
        wb_ready = 1'b0;
        tick(); tick(); tick();
        @(negedge clk);
        check_val("rst_wb_valid", 64'(wb_valid), 64'd0);
        check_val("rst_wb_rd", 64'(wb_rd), 64'd0);
        check_val("rst_wb_result", wb_result, 64'd0);
        check_val("rst_wb_hart", 64'(wb_hart), 64'd0);
        check_val("rst_overflow", 64'(overflow), 64'd0);
        check_val("rst_stall", 64'(unit_stall), 64'd0);
        tick();
        reset = 1'b0;

        // Single result on unit 0: latency check
        wb_ready = 1'b1;
        put(0, 5'd5, mkres(0, 60'h1234), 2'b01, 1'b1);
        tick();
        idle();
`ifndef WB_BYPASS_EN
        @(negedge clk);
        check_val("lat_early_valid", 64'(wb_valid), 64'd0);
        tick();
`endif
        @(negedge clk);
        check_val("lat_valid", 64'(wb_valid), 64'd1);
        check_val("lat_rd", 64'(wb_rd), 64'd5);
        check_val("lat_result", wb_result, 64'h1234);
        drain("lat_drain");

        // Grant unit 1 once so the round-robin pointer lands on 2
        put(1, 5'd20, mkres(1, 60'd20), 2'b01, 1'b1);
        tick();
        idle();
        drain("rr_setup_drain");

        // All four units at once: expected order 3,4,1,2 on consecutive cycles
        got_rd_q.delete();
        got_t_q.delete();
        for (int u = 0; u < NUNIT; u++) put(u, 5'(u + 1), mkres(u, 60'(u + 1)), 2'b01, 1'b1);
        tick();
        idle();
        drain("rr_drain");
        check_val("rr_count", 64'(got_rd_q.size()), 64'd4);
        check_val("rr_order0", 64'(got_rd_q[0]), 64'd3);
        check_val("rr_order1", 64'(got_rd_q[1]), 64'd4);
        check_val("rr_order2", 64'(got_rd_q[2]), 64'd1);
        check_val("rr_order3", 64'(got_rd_q[3]), 64'd2);
        check_val("rr_span", 64'(got_t_q[3] - got_t_q[0]), 64'd30);

        // Blocked output: one entry in the output register plus DEPTH queued, the next one drops
        wb_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            put(1, 5'(10 + i), mkres(1, 60'(i)), 2'b01, i <= 5);
            tick();
            @(negedge clk);
            if (i == 2) check_val("stall_low", 64'(unit_stall[1]), 64'd0);
            if (i == 3) check_val("stall_high", 64'(unit_stall[1]), 64'd1);
            if (i == 5) check_val("ovf_before", 64'(overflow), 64'd0);
            if (i == 6) check_val("ovf_after", 64'(overflow), 64'd1);
        end
        tick();
        idle();
        wb_ready = 1'b1;
        drain("ovf_drain");
        check_val("ovf_sticky", 64'(overflow), 64'd1);
        check_val("stall_released", 64'(unit_stall), 64'd0);

        // Output held stable while wb_ready is low
        wb_ready = 1'b0;
        put(2, 5'd9, mkres(2, 60'd9), 2'b01, 1'b1);
        tick();
        put(2, 5'd10, mkres(2, 60'd10), 2'b01, 1'b1);
        tick();
        idle();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_val("hold_valid", 64'(wb_valid), 64'd1);
            check_val("hold_rd", 64'(wb_rd), 64'd9);
            check_val("hold_result", wb_result, mkres(2, 60'd9));
            tick();
        end
        wb_ready = 1'b1;
        @(negedge clk);
        check_val("hold_release_rd", 64'(wb_rd), 64'd9);
        tick();
        @(negedge clk);
        check_val("next_valid", 64'(wb_valid), 64'd1);
        check_val("next_rd", 64'(wb_rd), 64'd10);
        drain("hold_drain");

        // Flush of hart 1 while its entry sits in a queue; same-cycle hart-1 arrival dropped
        got_rd_q.delete();
        wb_ready = 1'b0;
        put(0, 5'd7, mkres(0, 60'd7), 2'b01, 1'b1);
        put(1, 5'd8, mkres(1, 60'd8), 2'b10, 1'b0);
        tick();
        idle();
        tick();
        flush = 2'b10;
        put(2, 5'd11, mkres(2, 60'd11), 2'b10, 1'b0);
        tick();
        idle();
        wb_ready = 1'b1;
        drain("flushq_drain");
        check_val("flushq_count", 64'(got_rd_q.size()), 64'd1);
        check_val("flushq_rd", 64'(got_rd_q[0]), 64'd7);

        // Flush of hart 1 while its entry is in the output register, with wb_ready high
        got_rd_q.delete();
        wb_ready = 1'b0;
        put(1, 5'd12, mkres(1, 60'd12), 2'b10, 1'b0);
        put(0, 5'd13, mkres(0, 60'd13), 2'b01, 1'b1);
        tick();
        idle();
        tick();
        @(negedge clk);
        check_val("flusho_pre_rd", 64'(wb_rd), 64'd12);
        check_val("flusho_pre_hart", 64'(wb_hart), 64'd2);
        tick();
        flush    = 2'b10;
        wb_ready = 1'b1;
        tick();
        idle();
        @(negedge clk);
        check_val("flusho_valid", 64'(wb_valid), 64'd1);
        check_val("flusho_rd", 64'(wb_rd), 64'd13);
        drain("flusho_drain");
        check_val("flusho_count", 64'(got_rd_q.size()), 64'd1);
        check_val("flusho_first", 64'(got_rd_q[0]), 64'd13);

        // Reset with entries in flight: everything is lost, no writebacks afterwards
        wb_ready = 1'b0;
        put(0, 5'd21, mkres(0, 60'd21), 2'b01, 1'b0);
        put(1, 5'd22, mkres(1, 60'd22), 2'b01, 1'b0);
        put(2, 5'd23, mkres(2, 60'd23), 2'b01, 1'b0);
        tick();
        idle();
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        check_val("rst2_wb_valid", 64'(wb_valid), 64'd0);
        check_val("rst2_wb_rd", 64'(wb_rd), 64'd0);
        check_val("rst2_wb_result", wb_result, 64'd0);
        check_val("rst2_wb_hart", 64'(wb_hart), 64'd0);
        check_val("rst2_overflow", 64'(overflow), 64'd0);
        check_val("rst2_stall", 64'(unit_stall), 64'd0);
        tick();
        reset    = 1'b0;
        wb_ready = 1'b1;
        got_rd_q.delete();
        for (int c = 0; c < 10; c++) tick();
        check_val("rst2_no_wb", 64'(got_rd_q.size()), 64'd0);

        // Random traffic from units that honour unit_stall; the scoreboard checks per-unit order
        for (int c = 0; c < 80; c++) begin
            idle();
            wb_ready = ($urandom_range(0, 3) != 0);
            for (int u = 0; u < NUNIT; u++) begin
                if (!unit_stall[u] && $urandom_range(0, 1) == 1) begin
                    rnd = {$urandom, $urandom};
                    put(u, 5'($urandom_range(0, 31)), mkres(u, rnd[59:0]),
                        ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01, 1'b1);
                end
            end
            tick();
        end
        idle();
        wb_ready = 1'b1;
        drain("rnd_drain");
        check_val("rnd_no_overflow", 64'(overflow), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
